// File: rtl/riscv_test_monitor_if.sv
// riscv_test_monitor_if: taps on the core's I-mem, D-mem and RegFile write buses
interface riscv_test_monitor_if;
  logic        I_MEM_CSN;
  logic [31:0] I_MEM_ADDR;
  logic        D_MEM_CSN;
  logic        D_MEM_WEN;
  logic [31:0] D_MEM_ADDR;
  logic [31:0] D_MEM_DI;
  logic        RF_WE;
  logic [4:0]  RF_WA;
  logic [31:0] RF_WD;
  modport master (output I_MEM_CSN, I_MEM_ADDR, D_MEM_CSN, D_MEM_WEN, D_MEM_ADDR, D_MEM_DI, RF_WE, RF_WA, RF_WD);
  modport slave  (input  I_MEM_CSN, I_MEM_ADDR, D_MEM_CSN, D_MEM_WEN, D_MEM_ADDR, D_MEM_DI, RF_WE, RF_WA, RF_WD);
endinterface

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: passive end-of-test detector (tohost/self-loop/timeout) with run counters
module riscv_test_monitor #(
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_3FF0,
  parameter int          LOOP_THRESH = 32,
  parameter logic [31:0] MAX_CYCLES  = 32'd100000,
  parameter int          CNT_W       = 32
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  riscv_test_monitor_if.slave   bus,
  output logic                  DONE,
  output logic                  PASS,
  output logic                  TIMEOUT,
  output logic [31:0]           FAIL_CODE,
  output logic [CNT_W-1:0]      CYCLE_CNT,
  output logic [CNT_W-1:0]      WB_CNT
);
  localparam int LW = $clog2(LOOP_THRESH + 1);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d, wb_q, wb_d;
  logic [31:0]       x10_q, x10_d, last_q, last_d, fc_q, fc_d;
  logic [LW-1:0]     loop_q, loop_d;
  logic              done_q, done_d, pass_q, pass_d, to_q, to_d;
  logic              run, fetch, tohost, loop_hit, timeout_hit, ended;
  always_comb begin
    run         = state_q == RUN;
    fetch       = run && !bus.I_MEM_CSN;
    // word match: the low two address bits are ignored
    tohost      = run && !bus.D_MEM_CSN && !bus.D_MEM_WEN && ((bus.D_MEM_ADDR ^ TOHOST_ADDR) >> 2) == 32'd0;
    x10_d       = (run && bus.RF_WE && bus.RF_WA == 5'd10) ? bus.RF_WD : x10_q;
    loop_d      = !fetch ? loop_q :
                  bus.I_MEM_ADDR != last_q ? LW'(1) :
                  loop_q == LW'(LOOP_THRESH) ? loop_q : loop_q + 1'b1;
    last_d      = fetch ? bus.I_MEM_ADDR : last_q;
    loop_hit    = fetch && loop_d == LW'(LOOP_THRESH);
    timeout_hit = run && cyc_q == CNT_W'(MAX_CYCLES - 32'd1);
    ended       = tohost || loop_hit || timeout_hit;
    cyc_d       = (run && ~&cyc_q) ? cyc_q + 1'b1 : cyc_q;
    wb_d        = (run && bus.RF_WE && |bus.RF_WA && ~&wb_q) ? wb_q + 1'b1 : wb_q;
    state_d     = (state_q == IDLE && !bus.I_MEM_CSN) ? RUN : ended ? HALT : state_q;
    done_d      = done_q || ended;
    pass_d      = tohost ? bus.D_MEM_DI == 32'd1 : loop_hit ? x10_d == 32'd0 : pass_q;
    to_d        = to_q || (timeout_hit && !tohost && !loop_hit);
    fc_d        = tohost ? bus.D_MEM_DI >> 1 : loop_hit ? x10_d : fc_q;
  end
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      wb_q    <= '0;
      x10_q   <= '0;
      last_q  <= '0;
      loop_q  <= '0;
      fc_q    <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      wb_q    <= wb_d;
      x10_q   <= x10_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      fc_q    <= fc_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
    end
  end
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign TIMEOUT   = to_q;
  assign FAIL_CODE = fc_q;
  assign CYCLE_CNT = cyc_q;
  assign WB_CNT    = wb_q;
endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb_riscv_test_monitor: vector table plus hand sequences, scoreboarded against DUT outputs
module tb_riscv_test_monitor;
  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;
  riscv_test_monitor_if bus();
  logic        DONE, PASS, TIMEOUT;
  logic [31:0] FAIL_CODE, CYCLE_CNT, WB_CNT;
  riscv_test_monitor #(.MAX_CYCLES(32'd50)) dut (
    .CLK(CLK), .RSTn(RSTn), .bus(bus), .DONE(DONE), .PASS(PASS), .TIMEOUT(TIMEOUT),
    .FAIL_CODE(FAIL_CODE), .CYCLE_CNT(CYCLE_CNT), .WB_CNT(WB_CNT)
  );
  typedef struct {logic done, pass, to; logic [31:0] fc, cyc, wb;} exp_t;
  typedef struct {int kind; int n; logic [31:0] addr, data; exp_t e;} vec_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic check_pop(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("%s.done", nm), DONE, e.done);
    chk($sformatf("%s.pass", nm), PASS, e.pass);
    chk($sformatf("%s.timeout", nm), TIMEOUT, e.to);
    chk($sformatf("%s.fail_code", nm), FAIL_CODE, e.fc);
    chk($sformatf("%s.cycle_cnt", nm), CYCLE_CNT, e.cyc);
    chk($sformatf("%s.wb_cnt", nm), WB_CNT, e.wb);
  endtask
  task automatic idle();
    bus.I_MEM_CSN = 1'b1; bus.I_MEM_ADDR = '0;
    bus.D_MEM_CSN = 1'b1; bus.D_MEM_WEN = 1'b1; bus.D_MEM_ADDR = '0; bus.D_MEM_DI = '0;
    bus.RF_WE = 1'b0; bus.RF_WA = '0; bus.RF_WD = '0;
  endtask
  task automatic step();
    @(negedge CLK);
  endtask
  task automatic fetch(input logic [31:0] a);
    bus.I_MEM_CSN = 1'b0; bus.I_MEM_ADDR = a;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.D_MEM_CSN = 1'b0; bus.D_MEM_WEN = 1'b0; bus.D_MEM_ADDR = a; bus.D_MEM_DI = d;
  endtask
  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    bus.RF_WE = 1'b1; bus.RF_WA = a; bus.RF_WD = d;
  endtask
  task automatic do_reset();
    RSTn = 1'b0;
    idle();
    step();
    RSTn = 1'b1;
  endtask
  task automatic enter();
    idle();
    fetch(32'h0);
    step();
  endtask
  task automatic drive_vec(input vec_t v, input int k);
    idle();
    if (v.kind == 0) begin
      if (k < v.n) begin
        fetch(32'(4 * (k + 1)));
        rf_write(5'(k), 32'(k));
      end else if (k == v.n) store(v.addr, v.data);
    end else if (v.kind == 1) begin
      if (k == 0) rf_write(5'd10, v.data);
      else if (k <= v.n) fetch(32'h40);
    end else fetch(32'(4 * (k + 1)));
  endtask
  task automatic wait_done(input vec_t v, input string nm);
    bit got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      drive_vec(v, k);
      step();
      got = DONE;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s: DONE not seen within 200 cycles got 0 want 1", nm);
    end
  endtask
  vec_t vecs[8];
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vec_t v;
    vecs[0] = '{0, 5,  32'h3FF0, 32'h1,         '{1'b1, 1'b1, 1'b0, 32'h0,        32'd6,  32'd4}};
    vecs[1] = '{0, 3,  32'h3FF0, 32'h7,         '{1'b1, 1'b0, 1'b0, 32'h3,        32'd4,  32'd2}};
    vecs[2] = '{0, 2,  32'h3FF3, 32'hFFFF_FFFF, '{1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'd3, 32'd1}};
    vecs[3] = '{0, 4,  32'h3FF2, 32'h0,         '{1'b1, 1'b0, 1'b0, 32'h0,        32'd5,  32'd3}};
    vecs[4] = '{1, 32, 32'h0,    32'h0,         '{1'b1, 1'b1, 1'b0, 32'h0,        32'd33, 32'd1}};
    vecs[5] = '{1, 32, 32'h0,    32'h5,         '{1'b1, 1'b0, 1'b0, 32'h5,        32'd33, 32'd1}};
    vecs[6] = '{1, 32, 32'h0,    32'h8000_0000, '{1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd33, 32'd1}};
    vecs[7] = '{2, 0,  32'h0,    32'h0,         '{1'b1, 1'b0, 1'b1, 32'h0,        32'd50, 32'd0}};
    idle();
    step();
    sb.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0});
    check_pop("reset");
    for (int i = 0; i < 8; i++) begin
      do_reset();
      enter();
      sb.push_back(vecs[i].e);
      wait_done(vecs[i], $sformatf("vec%0d", i));
      check_pop($sformatf("vec%0d", i));
    end
    // tohost store lands on the same posedge the failing self-loop completes
    do_reset();
    enter();
    v = vecs[5];
    sb.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 32'd33, 32'd1});
    for (int k = 0; k <= 32; k++) begin
      drive_vec(v, k);
      if (k == 32) store(32'h3FF0, 32'h1);
      step();
    end
    check_pop("prio_tohost_loop");
    // self-loop completes on the same posedge the timeout would fire
    do_reset();
    enter();
    sb.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 32'd50, 32'd0});
    for (int k = 0; k < 50; k++) begin
      idle();
      fetch(k < 18 ? 32'(4 * (k + 1)) : 32'h40);
      step();
      if (k == 48) chk("prio_loop_timeout.early_done", DONE, 1'b0);
    end
    check_pop("prio_loop_timeout");
    do_reset();
    idle();
    store(32'h3FF0, 32'h1);
    step();
    sb.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0});
    check_pop("idle_store_ignored");
    enter();
    idle();
    fetch(32'h4);
    bus.D_MEM_CSN = 1'b0; bus.D_MEM_WEN = 1'b1; bus.D_MEM_ADDR = 32'h3FF0; bus.D_MEM_DI = 32'h1;
    step();
    chk("tohost_read.done", DONE, 1'b0);
    idle();
    store(32'h3FF0, 32'h7);
    step();
    sb.push_back('{1'b1, 1'b0, 1'b0, 32'h3, 32'd2, 32'd0});
    check_pop("store7");
    for (int k = 0; k < 3; k++) begin
      idle();
      fetch(32'h8);
      store(32'h3FF0, 32'h1);
      rf_write(5'd5, 32'h1);
      step();
    end
    sb.push_back('{1'b1, 1'b0, 1'b0, 32'h3, 32'd2, 32'd0});
    check_pop("halt_sticky");
    do_reset();
    enter();
    for (int k = 0; k < 20; k++) begin
      idle();
      fetch(32'(4 * (k + 1)));
      if (k < 9) rf_write(5'(k + 1), 32'(k));
      else if (k < 14) rf_write(5'd0, 32'hDEAD);
      step();
    end
    sb.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'd20, 32'd9});
    check_pop("mid_run");
    #2;
    RSTn = 1'b0;
    #1;
    sb.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0});
    check_pop("async_reset");
    idle();
    step();
    RSTn = 1'b1;
    enter();
    idle();
    store(32'h3FF0, 32'h1);
    step();
    sb.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 32'd1, 32'd0});
    check_pop("restart");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
